// File: rtl/hist_pkg.sv
// Shared sizes, types and helpers for the per-frame histogram accumulator.
package hist_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned BINS  = 1 << PIX_W;
    localparam int unsigned CNT_W = 22;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PIX_W-1:0] bin_t;

    typedef enum logic [1:0] {INIT, IDLE, DRAIN, DUMP} hist_st_t;

    function automatic cnt_t sat_add(input cnt_t a, input cnt_t b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/hist_bank_ram.sv
// Simple dual-port RAM, one write and one registered read port (read returns old data on collision).
module hist_bank_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 22
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hist_accum.sv
// Ping-pong 256-bin histogram: one bank accumulates pixels, the other streams out with clear-on-read.
// Define HIST_CDF_EN to stream the saturating cumulative sum instead of raw bin counts.
module hist_accum
    import hist_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_comp,
    input  logic             frame_end,
    input  logic             hist_ready,
    output logic             hist_valid,
    output logic [PIX_W-1:0] hist_bin,
    output logic [CNT_W-1:0] hist_cnt,
    output logic             hist_last,
    output logic             busy,
    output logic             frame_drop
);

    hist_st_t       state_q, state_d;
    logic           acc_bank_q, acc_bank_d;
    bin_t           init_cnt_q, init_cnt_d;
    logic           drain_cnt_q, drain_cnt_d;

    logic           s0_go;
    logic           s1_valid_q, s1_fwd_q;
    bin_t           s1_bin_q;
    cnt_t           s1_fwd_data_q;
    logic           s2_valid_q;
    bin_t           s2_bin_q;
    cnt_t           s2_data_q, s2_data_d;
    cnt_t           s1_base;

    logic [PIX_W:0] rd_ptr_q, rd_ptr_d;
    logic           f_valid_q, f_valid_d;
    bin_t           f_bin_q, f_bin_d;
    bin_t           rd_addr;
    cnt_t           cum_q, cum_d;
    cnt_t           out_cnt;
    logic           xfer;

    logic           busy_q, drop_q;

    logic [1:0][CNT_W-1:0] ram_rdata;
    cnt_t           acc_rdata, dump_rdata;

    assign acc_rdata  = acc_bank_q ? ram_rdata[1] : ram_rdata[0];
    assign dump_rdata = acc_bank_q ? ram_rdata[0] : ram_rdata[1];

    // Each physical bank takes either the accumulate ports or the readout/clear ports.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic we;
        bin_t waddr, raddr;
        cnt_t wdata;

        always_comb begin
            we    = 1'b0;
            waddr = s2_bin_q;
            wdata = s2_data_q;
            raddr = in_comp;
            if (state_q == INIT) begin
                we    = 1'b1;
                waddr = init_cnt_q;
                wdata = '0;
            end else if (acc_bank_q == 1'(b)) begin
                we = s2_valid_q;
            end else begin
                we    = xfer;
                waddr = f_bin_q;
                wdata = '0;
                raddr = rd_addr;
            end
        end

        hist_bank_ram #(
            .ADDR_W (PIX_W),
            .DATA_W (CNT_W)
        ) u_ram (
            .clk   (clk),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (raddr),
            .rdata (ram_rdata[b])
        );
    end

    // Accumulate pipeline: newest in-flight write wins over the value captured at read issue.
    always_comb begin
        s0_go = in_valid && (state_q == IDLE || state_q == DUMP);
        if (s2_valid_q && s2_bin_q == s1_bin_q) begin
            s1_base = s2_data_q;
        end else if (s1_fwd_q) begin
            s1_base = s1_fwd_data_q;
        end else begin
            s1_base = acc_rdata;
        end
        s2_data_d = sat_add(s1_base, cnt_t'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_bin_q      <= '0;
            s1_fwd_q      <= 1'b0;
            s1_fwd_data_q <= '0;
            s2_valid_q    <= 1'b0;
            s2_bin_q      <= '0;
            s2_data_q     <= '0;
        end else begin
            s1_valid_q    <= s0_go;
            s1_bin_q      <= in_comp;
            s1_fwd_q      <= s2_valid_q && (s2_bin_q == in_comp);
            s1_fwd_data_q <= s2_data_q;
            s2_valid_q    <= s1_valid_q;
            s2_bin_q      <= s1_bin_q;
            s2_data_q     <= s2_data_d;
        end
    end

    assign xfer = f_valid_q && hist_ready;

    always_comb begin
`ifdef HIST_CDF_EN
        out_cnt = sat_add(cum_q, dump_rdata);
`else
        out_cnt = dump_rdata;
`endif
    end

    always_comb begin
        state_d     = state_q;
        acc_bank_d  = acc_bank_q;
        init_cnt_d  = init_cnt_q;
        drain_cnt_d = drain_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        f_valid_d   = f_valid_q;
        f_bin_d     = f_bin_q;
        cum_d       = cum_q;
        rd_addr     = rd_ptr_q[PIX_W-1:0];
        unique case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == bin_t'(BINS - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (frame_end) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            DRAIN: begin
                drain_cnt_d = 1'b1;
                rd_ptr_d    = '0;
                f_valid_d   = 1'b0;
                cum_d       = '0;
                if (drain_cnt_q) begin
                    state_d    = DUMP;
                    acc_bank_d = !acc_bank_q;
                end
            end
            DUMP: begin
                if (xfer) begin
                    cum_d = out_cnt;
                end
                // While stalled the held bin is re-read so the RAM output stays put.
                if (!f_valid_q || xfer) begin
                    if (!rd_ptr_q[PIX_W]) begin
                        f_valid_d = 1'b1;
                        f_bin_d   = rd_ptr_q[PIX_W-1:0];
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                    end else begin
                        f_valid_d = 1'b0;
                    end
                end else begin
                    rd_addr = f_bin_q;
                end
                if (xfer && f_bin_q == bin_t'(BINS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            acc_bank_q  <= 1'b0;
            init_cnt_q  <= '0;
            drain_cnt_q <= 1'b0;
            rd_ptr_q    <= '0;
            f_valid_q   <= 1'b0;
            f_bin_q     <= '0;
            cum_q       <= '0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_bank_q  <= acc_bank_d;
            init_cnt_q  <= init_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            f_valid_q   <= f_valid_d;
            f_bin_q     <= f_bin_d;
            cum_q       <= cum_d;
            busy_q      <= (state_d != IDLE);
            drop_q      <= frame_end && (state_q == DRAIN || state_q == DUMP);
        end
    end

    assign hist_valid = f_valid_q;
    assign hist_bin   = f_bin_q;
    assign hist_cnt   = f_valid_q ? out_cnt : '0;
    assign hist_last  = f_valid_q && (f_bin_q == bin_t'(BINS - 1));
    assign busy       = busy_q;
    assign frame_drop = drop_q;

endmodule

// File: tb/tb_hist_accum.sv
// Randomised scoreboard bench for hist_accum: a per-bin count array models each frame.
module tb_hist_accum;
    import hist_pkg::*;

    typedef struct packed {
        bin_t bin;
        cnt_t cnt;
        logic last;
    } exp_t;

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic clk        = 1'b0;
    logic reset_n    = 1'b0;
    logic in_valid   = 1'b0;
    bin_t in_comp    = '0;
    logic frame_end  = 1'b0;
    logic hist_ready = 1'b1;
    logic hist_valid;
    bin_t hist_bin;
    cnt_t hist_cnt;
    logic hist_last;
    logic busy;
    logic frame_drop;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];
    int unsigned acc[BINS];
    int fe_accepted = 0;
    int last_seen = 0;
    int drops_exp = 0;
    int drops_seen = 0;
    bit mon_en = 1'b0;
    bit rdy_rand = 1'b0;

    hist_accum u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_comp    (in_comp),
        .frame_end  (frame_end),
        .hist_ready (hist_ready),
        .hist_valid (hist_valid),
        .hist_bin   (hist_bin),
        .hist_cnt   (hist_cnt),
        .hist_last  (hist_last),
        .busy       (busy),
        .frame_drop (frame_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        hist_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops expected words on every transfer and checks holding while stalled.
    exp_t e;
    bit   prev_stall = 1'b0;
    bin_t prev_bin;
    cnt_t prev_cnt;
    logic prev_last;

    always @(negedge clk) begin
        if (frame_drop) drops_seen++;
        if (!mon_en || !reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(hist_valid && hist_bin == prev_bin && hist_cnt == prev_cnt &&
                      hist_last == prev_last)) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%0d bin=%0d cnt=%0d last=%0d, required valid=1 bin=%0d cnt=%0d last=%0d",
                             hist_valid, hist_bin, hist_cnt, hist_last, prev_bin, prev_cnt, prev_last);
                end
            end
            if (hist_valid && hist_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got bin=%0d cnt=%0d, required no word", hist_bin, hist_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (hist_bin != e.bin || hist_cnt != e.cnt || hist_last != e.last) begin
                        failures++;
                        $display("FAIL readout_word: got bin=%0d cnt=%0d last=%0d, required bin=%0d cnt=%0d last=%0d",
                                 hist_bin, hist_cnt, hist_last, e.bin, e.cnt, e.last);
                    end
                    if (e.last) last_seen++;
                end
            end
            prev_stall = hist_valid && !hist_ready;
            prev_bin   = hist_bin;
            prev_cnt   = hist_cnt;
            prev_last  = hist_last;
        end
    end

    function automatic bit ro_pend();
        return fe_accepted != last_seen;
    endfunction

    function automatic int rand_pix();
        return $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255));
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Snapshot the live frame as expected readout words, then start a fresh frame.
    task automatic push_frame();
        longint run;
        longint v;
        exp_t w;
        run = 0;
        for (int b = 0; b < BINS; b++) begin
            run += acc[b];
`ifdef HIST_CDF_EN
            v = run;
`else
            v = acc[b];
`endif
            if (v > CNT_MAX) v = CNT_MAX;
            w.bin  = bin_t'(b);
            w.cnt  = cnt_t'(v);
            w.last = (b == BINS - 1);
            exp_q.push_back(w);
            acc[b] = 0;
        end
    endtask

    task automatic drive(input bit v, input int c, input bit fe);
        bit accepted;
        accepted  = 1'b0;
        in_valid  = v;
        in_comp   = bin_t'(c);
        frame_end = fe;
        if (v) acc[c]++;
        if (fe) begin
            if (ro_pend()) begin
                drops_exp++;
            end else begin
                push_frame();
                fe_accepted++;
                accepted = 1'b1;
            end
        end
        cycle();
        in_valid  = 1'b0;
        frame_end = 1'b0;
        if (accepted) begin
            cycle();
            cycle();
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 4000) begin
            cycle();
            n++;
        end
        check(n < 4000, name, n, 4000);
    endtask

    // Waits out INIT while offering pixels and a frame_end that must be ignored.
    task automatic wait_init();
        int n;
        bit saw;
        n = 0;
        saw = 1'b0;
        while (n < 400) begin
            in_valid  = (n >= 40 && n < 60);
            in_comp   = 8'h22;
            frame_end = (n == 50);
            cycle();
            n++;
            if (busy) saw = 1'b1;
            else if (saw) break;
        end
        in_valid  = 1'b0;
        frame_end = 1'b0;
        check(saw, "init_busy_high", saw, 1);
        check(n >= 256 && n <= 257, "init_length", n, 256);
    endtask

    initial begin
        int lat;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check(hist_valid == 1'b0, "reset_hist_valid", hist_valid, 0);
        check(hist_bin == '0, "reset_hist_bin", hist_bin, 0);
        check(hist_cnt == '0, "reset_hist_cnt", hist_cnt, 0);
        check(hist_last == 1'b0, "reset_hist_last", hist_last, 0);
        check(busy == 1'b0, "reset_busy", busy, 0);
        check(frame_drop == 1'b0, "reset_frame_drop", frame_drop, 0);

        reset_n = 1'b1;
        wait_init();
        mon_en = 1'b1;

        // Empty frame, with first-word latency.
        frame_end = 1'b1;
        push_frame();
        fe_accepted++;
        cycle();
        frame_end = 1'b0;
        lat = 1;
        while (!hist_valid && lat < 20) begin
            cycle();
            lat++;
        end
        check(lat >= 4 && lat <= 5, "first_word_latency", lat, 4);
        wait_done("empty_frame_timeout");

        // Long run of one value exercises the forwarding paths.
        repeat (1000) drive(1'b1, 'h37, 1'b0);
        drive(1'b0, 0, 1'b1);
        wait_done("run37_timeout");

        // Same alternating frame twice: second readout relies on clear-on-read.
        repeat (2) begin
            for (int i = 0; i < 900; i++) drive(1'b1, (i % 3 == 1) ? 'h11 : 'h10, 1'b0);
            drive(1'b0, 0, 1'b1);
            wait_done("alt_timeout");
        end

        // Sparse bins including the top one.
        for (int k = 0; k < 3; k++) begin
            repeat (4) drive(1'b1, (k == 2) ? 255 : k, 1'b0);
        end
        drive(1'b0, 0, 1'b1);
        wait_done("sparse_timeout");

        // Random frame, then random backpressure with next-frame pixels and a refused frame_end.
        rdy_rand = 1'b1;
        for (int i = 0; i < 600; i++) drive($urandom_range(0, 9) < 8, rand_pix(), 1'b0);
        drive(1'b1, rand_pix(), 1'b1);
        n = 0;
        while (ro_pend() && n < 5000) begin
            if (n == 100) begin
                drive(1'b1, rand_pix(), 1'b1);
                drive(1'b1, rand_pix(), 1'b0);
                n++;
                check(drops_seen == drops_exp, "frame_drop_pulse", drops_seen, drops_exp);
            end else begin
                drive($urandom_range(0, 9) < 7, rand_pix(), 1'b0);
            end
            n++;
        end
        check(!ro_pend(), "random_dump_timeout", n, 5000);
        drive(1'b0, 0, 1'b1);
        wait_done("merged_timeout");
        rdy_rand = 1'b0;

        // Reset in the middle of a readout.
        for (int i = 0; i < 200; i++) drive(1'b1, rand_pix(), 1'b0);
        drive(1'b0, 0, 1'b1);
        repeat (20) cycle();
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check(hist_valid == 1'b0, "abort_hist_valid", hist_valid, 0);
        check(hist_cnt == '0, "abort_hist_cnt", hist_cnt, 0);
        check(busy == 1'b0, "abort_busy", busy, 0);
        exp_q.delete();
        fe_accepted = last_seen;
        for (int b = 0; b < BINS; b++) acc[b] = 0;
        cycle();
        reset_n = 1'b1;
        wait_init();
        mon_en = 1'b1;
        drive(1'b0, 0, 1'b1);
        wait_done("post_reset_timeout");

        repeat (4) cycle();
        check(drops_seen == drops_exp, "total_frame_drops", drops_seen, drops_exp);
        check(exp_q.size() == 0, "leftover_expected", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
